// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, instruction register, req/ack fetch FSM and return-address stack
module instruction_fetch #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    STACK_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_start,
    input  logic                  PCWrite,
    input  logic [1:0]            pcSrc,
    input  logic                  branch_cond,
    input  logic                  push,
    input  logic                  pop,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_ack,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           ir,
    output logic [5:0]            opcode,
    output logic                  ir_valid,
    output logic                  fetch_done,
    output logic                  busy,
    output logic                  stack_err
);

    localparam int SPW = $clog2(STACK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] JMASK = ADDR_WIDTH'(26'h3FF_FFFF);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] pc_plus1, branch_off, jump_target, top, pc_next;
    logic [SPW:0]          sp;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                  idle, stack_empty, stack_full, stack_we;
    logic [SPW-1:0]        wr_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            S_IDLE: if (fetch_start) state_d = S_WAIT;
            S_WAIT: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign idle        = (state_q == S_IDLE);
    assign imem_addr   = fetch_addr;
    assign opcode      = ir[31:26];
    assign pc_plus1    = pc + ADDR_WIDTH'(1);
    assign branch_off  = ADDR_WIDTH'($signed(ir[15:0]));
    // Jump keeps the PC bits above the 26-bit field when the PC is wider than it.
    assign jump_target = (pc & ~JMASK) | (ADDR_WIDTH'(ir[25:0]) & JMASK);
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == (SPW+1)'(STACK_DEPTH));
    assign top         = stack_empty ? '0 : stack_mem[SPW'(sp - (SPW+1)'(1))];

    always_comb begin
        pc_next = pc_plus1;
        unique case (pcSrc)
            2'b00: pc_next = pc_plus1;
            2'b01: pc_next = branch_cond ? pc_plus1 + branch_off : pc_plus1;
            2'b10: pc_next = jump_target;
            2'b11: pc_next = top;
            default: pc_next = pc_plus1;
        endcase
    end

    // Push+pop on a non-empty stack overwrites the top entry in place.
    assign wr_idx   = (pop && !stack_empty) ? SPW'(sp - (SPW+1)'(1)) : SPW'(sp);
    assign stack_we = idle && push && (pop || !stack_full);

    always_ff @(posedge clk) begin
        if (stack_we) stack_mem[wr_idx] <= pc_plus1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp        <= '0;
            stack_err <= 1'b0;
        end else if (idle) begin
            if (push && pop) begin
                if (stack_empty) begin
                    sp        <= (SPW+1)'(1);
                    stack_err <= 1'b1;
                end
            end else if (push) begin
                if (stack_full) stack_err <= 1'b1;
                else            sp <= sp + (SPW+1)'(1);
            end else if (pop) begin
                if (stack_empty) stack_err <= 1'b1;
                else             sp <= sp - (SPW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            ir         <= '0;
            ir_valid   <= 1'b0;
            fetch_done <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            if (idle) begin
                if (fetch_start) fetch_addr <= pc;
                if (PCWrite) begin
                    pc <= pc_next;
                    if (pc_next != pc) ir_valid <= 1'b0;
                end
            end else if (imem_ack) begin
                ir         <= imem_rdata;
                ir_valid   <= 1'b1;
                fetch_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the Core Musa multicycle datapath, directly upstream of `unit_Control`. It holds the program counter and instruction register and fetches from instruction memory with a req/ack handshake. It presents `opcode` and the raw instruction to the control unit and the decode logic. It computes the next PC from the control unit's `pcSrc`/`PCWrite`/`push`/`pop` outputs, using an internal return-address stack for call/return.

## Interface
- `ADDR_WIDTH`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 0: PC value after reset.
- `STACK_DEPTH`, 8: return-address stack entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state is cleared while `reset`=0.
- `fetch_start`  in  1  one-cycle request from the control unit (fetch stage) to fetch at current PC.
- `PCWrite`  in  1  commit next PC this cycle.
- `pcSrc`  in  2  next-PC select: 00 PC+1, 01 branch, 10 jump, 11 return (pop).
- `branch_cond`  in  1  branch condition from ALU; used only when `pcSrc`=01.
- `push`  in  1  push PC+1 onto return stack (call).
- `pop`  in  1  pop return stack (return).
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  ADDR_WIDTH  request address (= `pc`).
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `imem_ack`  in  1  memory acknowledge; may be asserted in the same cycle as `imem_req`.
- `pc`  out  ADDR_WIDTH  current PC.
- `ir`  out  32  instruction register.
- `opcode`  out  6  `ir[31:26]`.
- `ir_valid`  out  1  `ir` holds the instruction fetched at `pc`.
- `fetch_done`  out  1  one-cycle pulse when `ir` is updated.
- `busy`  out  1  fetch in progress.
- `stack_err`  out  1  sticky overflow/underflow flag.

## Operation
- Reset values: `pc`=RESET_PC, `ir`=0, `opcode`=0, `ir_valid`=0, `fetch_done`=0, `busy`=0, `imem_req`=0, `stack_err`=0, stack pointer `sp`=0 (empty). Stack contents are don't-care.
- FSM states:
  - IDLE: `fetch_start` moves to WAIT and sets `imem_req`=1 and `busy`=1.
  - WAIT: holds `imem_req` and `imem_addr` stable until `imem_ack`=1. On ack, `ir`<=`imem_rdata` and the FSM goes to IDLE.
- `fetch_start` while `busy` is ignored.
- `ir_valid` goes to 1 when `ir` is loaded and clears when the PC changes.
- Next PC on `PCWrite`:
  - 00: PC+1.
  - 01: PC+1+sext(`ir[15:0]`) if `branch_cond`, else PC+1.
  - 10: {PC[ADDR_WIDTH-1:26 or 0], `ir[25:0]`} truncated to ADDR_WIDTH.
  - 11: top of stack.
- Arithmetic is modulo 2^ADDR_WIDTH; PC wraps from all-ones to 0.
- `PCWrite` while `busy` is ignored: PC is unchanged and no stack operation occurs.
- Stack:
  - `push` writes PC+1 at `sp`, then `sp`++.
  - `pop` returns entry `sp-1`, then `sp`--.
  - `push` and `pop` act independently of `PCWrite` but are ignored while `busy`.
- `push` and `pop` together: the top entry is replaced with PC+1, `sp` is unchanged, and the popped value is the old top.
- Overflow (push when `sp`=STACK_DEPTH): the write is dropped and `stack_err` is set.
- Underflow (pop when empty): the popped value is 0 and `stack_err` is set.
- `stack_err` clears only on reset.

## Timing
- `fetch_start` sampled at edge N: `imem_req`=1 and `busy`=1 from N+1.
- `imem_ack` sampled high at edge M (M≥N+1): `ir`/`opcode` are updated, `fetch_done`=1, `ir_valid`=1, `imem_req`=0, `busy`=0, all visible after M.
- Minimum fetch latency is 2 cycles, from `fetch_start` to `opcode` valid.
- `fetch_done` is high exactly one cycle.
- `PCWrite` at edge K: new `pc` visible after K. A `fetch_start` in the same cycle as `PCWrite` fetches the old PC.
- Stack read for `pcSrc`=11 is combinational from the current top, so a pop and `PCWrite` in the same cycle use the pre-pop top.
- Reset asserted mid-fetch drops `imem_req` immediately (asynchronous). A pending `imem_ack` after reset release is ignored in IDLE.

## Test plan
- Reset, then `fetch_start` with `imem_rdata`=0x7000_0000 and ack on the first req cycle -> `opcode`=6'b011100 two cycles later, `fetch_done` pulses once, `pc`=0.
- Ack delayed 3 cycles -> `imem_req`/`imem_addr` stable for 4 cycles; `PCWrite` and `fetch_start` during the wait leave `pc` unchanged and do not restart the fetch.
- `pc`=0x0010, `ir[15:0]`=0xFFFC, `pcSrc`=01 -> `pc`=0x000D with `branch_cond`=1, and `pc`=0x0011 with `branch_cond`=0.
- Call/return at `pc`=0x0020: `push`+`PCWrite` with `pcSrc`=10 and target 0x0100 -> `pc`=0x0100. A later `pop`+`PCWrite` with `pcSrc`=11 -> `pc`=0x0021, stack empty.
- 9 pushes with STACK_DEPTH=8 -> `stack_err`=1 after the 9th push; 8 pops return the first 8 values in reverse order.
- A further pop -> `pc`=0 with `stack_err` still 1. Asynchronous reset mid-`WAIT` -> all outputs at their reset values before the next edge.
